// File: rtl/qspi_ram_responder.sv
// QSPI PSRAM responder: serves quad read (0xEB) and quad write (0x38) from an internal byte array,
// oversampling ram_clk in the system clock domain. Optional macro QSPI_RESP_SPI_INIT_EN adds SPI-mode boot (0x35 enters QPI).
module qspi_ram_responder #(
  parameter int          ADDR_W = 10,
  parameter int          DUMMY  = 6,
  parameter logic [1:0]  BANK   = 2'd0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_ram_csn,
  input  logic       in_ram_clk,
  input  logic [1:0] in_ram_bank,
  input  logic [3:0] in_ram_io,
  output logic [3:0] out_ram_io,
  output logic       out_ram_io_oe,
  output logic       out_active
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA, S_IGNORE
  } state_t;

`ifdef QSPI_RESP_SPI_INIT_EN
  localparam int SH_W = (ADDR_W - 4 > 7) ? ADDR_W - 4 : 7;
`else
  localparam int SH_W = (ADDR_W - 4 > 4) ? ADDR_W - 4 : 4;
`endif
  localparam logic [4:0]        DUMMY_LAST = 5'(DUMMY - 1);
  localparam logic [ADDR_W-1:0] ONE        = 1;

  state_t state, state_next;

  logic              r_clk, r_csn;
  logic              rise, fall, csn_fall;
  logic [4:0]        cnt;
  logic              rd, hi;
  logic              wr_en;
  logic [3:0]        wnib;
  logic [7:0]        wr_data, rd_byte, cmd_byte;
  logic [ADDR_W-1:0] addr, wr_addr, addr_new;
  logic [SH_W-1:0]   sh;
  logic              cmd_last, qpi;

  logic [7:0] mem [0:(1<<ADDR_W)-1];

  assign rise     = in_ram_clk & ~r_clk;
  assign fall     = ~in_ram_clk & r_clk;
  assign csn_fall = ~in_ram_csn & r_csn;
  assign addr_new = {sh[ADDR_W-5:0], in_ram_io};
  assign rd_byte  = mem[addr];

  // SPI mode shifts one bit per rise on io0; quad mode one nibble per rise
`ifdef QSPI_RESP_SPI_INIT_EN
  assign cmd_byte = qpi ? {sh[3:0], in_ram_io} : {sh[6:0], in_ram_io[0]};
  assign cmd_last = qpi ? (cnt == 5'd1) : (cnt == 5'd7);
`else
  assign qpi      = 1'b1;
  assign cmd_byte = {sh[3:0], in_ram_io};
  assign cmd_last = (cnt == 5'd1);
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    out_active = 1'b0;
    if (in_ram_csn) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (csn_fall)
                   state_next = (in_ram_bank == BANK) ? S_CMD : S_IGNORE;
        S_CMD:   if (rise && cmd_last)
                   state_next = (qpi && (cmd_byte == 8'hEB || cmd_byte == 8'h38)) ? S_ADDR : S_IGNORE;
        S_ADDR:  if (rise && cnt == 5'd5)
                   state_next = !rd ? S_WDATA : ((DUMMY == 0) ? S_RDATA : S_DUMMY);
        S_DUMMY: if (rise && cnt == DUMMY_LAST)
                   state_next = S_RDATA;
        default: ;
      endcase
    end
    case (state)
      S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA: out_active = 1'b1;
      default: ;
    endcase
  end

  // Control: edge detectors, phase counters, output drive, write strobe
  always_ff @(posedge clock) begin
    if (reset) begin
      r_clk         <= 1'b0;
      r_csn         <= 1'b0;
      cnt           <= 5'd0;
      rd            <= 1'b0;
      hi            <= 1'b1;
      wr_en         <= 1'b0;
      out_ram_io    <= 4'h0;
      out_ram_io_oe <= 1'b0;
`ifdef QSPI_RESP_SPI_INIT_EN
      qpi           <= 1'b0;
`endif
    end else begin
      r_clk <= in_ram_clk;
      r_csn <= in_ram_csn;
      wr_en <= 1'b0;
      if (state_next != state) cnt <= 5'd0;
      else if (rise)           cnt <= cnt + 5'd1;
      if (in_ram_csn) begin
        out_ram_io_oe <= 1'b0;
      end else begin
        case (state)
          S_CMD: if (rise && cmd_last) begin
            rd <= (cmd_byte == 8'hEB);
`ifdef QSPI_RESP_SPI_INIT_EN
            if (!qpi && cmd_byte == 8'h35) qpi <= 1'b1;
`endif
          end
          S_ADDR: hi <= 1'b1;
          S_RDATA: if (fall) begin
            out_ram_io    <= hi ? rd_byte[7:4] : rd_byte[3:0];
            out_ram_io_oe <= 1'b1;
            hi            <= ~hi;
          end
          S_WDATA: if (rise) begin
            hi    <= ~hi;
            wr_en <= ~hi;
          end
          default: ;
        endcase
      end
    end
  end

  // Datapath: command/address shifter, byte address, write staging
  always_ff @(posedge clock) begin
    if (!in_ram_csn) begin
      case (state)
        S_CMD: if (rise) begin
`ifdef QSPI_RESP_SPI_INIT_EN
          sh <= qpi ? {sh[SH_W-5:0], in_ram_io} : {sh[SH_W-2:0], in_ram_io[0]};
`else
          sh <= {sh[SH_W-5:0], in_ram_io};
`endif
        end
        S_ADDR: if (rise) begin
          sh <= {sh[SH_W-5:0], in_ram_io};
          if (cnt == 5'd5) addr <= addr_new;
        end
        S_RDATA: if (fall && !hi) addr <= addr + ONE;
        S_WDATA: if (rise) begin
          if (hi) begin
            wnib <= in_ram_io;
          end else begin
            wr_data <= {wnib, in_ram_io};
            wr_addr <= addr;
            addr    <= addr + ONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

endmodule

// File: tb/tb_qspi_ram_responder.sv
// Bench for qspi_ram_responder: directed and randomized quad transactions checked against a byte-array model.
// Define QSPI_RESP_SPI_INIT_EN for both files to exercise the SPI boot sequence.
module tb_qspi_ram_responder;
  localparam int PH    = 3;
  localparam int MEMSZ = 1024;
  localparam int NDUM  = 6;

  logic       clock = 1'b0;
  logic       reset, csn, sck;
  logic [1:0] bnk;
  logic [3:0] hio;
  logic [3:0] dio;
  logic       doe, dact;

  always #5 clock = ~clock;

  qspi_ram_responder dut (
    .clock(clock), .reset(reset), .in_ram_csn(csn), .in_ram_clk(sck),
    .in_ram_bank(bnk), .in_ram_io(hio), .out_ram_io(dio),
    .out_ram_io_oe(doe), .out_active(dact)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] model [0:MEMSZ-1];
  logic [7:0] wbuf  [0:15];
  logic [3:0] rnib  [0:31];
  logic [3:0] smp_io;
  logic       smp_oe, smp_act;
  int hdr_oe, hdr_act_hi, hdr_act_lo, data_oe;
  logic post_oe, post_act;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One SPI clock: low phase with host nibble, sample responder, then high phase
  task automatic sclk(input logic [3:0] v);
    hio = v;
    sck = 1'b0;
    repeat (PH) @(negedge clock);
    smp_io  = dio;
    smp_oe  = doe;
    smp_act = dact;
    sck = 1'b1;
    repeat (PH) @(negedge clock);
  endtask

  task automatic clr();
    hdr_oe = 0; hdr_act_hi = 0; hdr_act_lo = 0; data_oe = 0;
  endtask

  task automatic send(input logic [3:0] v);
    sclk(v);
    if (smp_oe) hdr_oe++;
    if (smp_act) hdr_act_hi++; else hdr_act_lo++;
  endtask

  task automatic start(input logic [1:0] b);
    bnk = b;
    sck = 1'b0;
    @(negedge clock);
    csn = 1'b0;
    repeat (PH) @(negedge clock);
  endtask

  task automatic stop();
    sck = 1'b0;
    repeat (PH) @(negedge clock);
    csn = 1'b1;
    repeat (PH) @(negedge clock);
    post_oe  = doe;
    post_act = dact;
  endtask

  task automatic hdr(input logic [7:0] cmd, input logic [23:0] a);
    send(cmd[7:4]);
    send(cmd[3:0]);
    for (int i = 5; i >= 0; i--) send(a[i*4 +: 4]);
  endtask

  task automatic qwrite(input logic [1:0] b, input logic [23:0] a, input int n, input bit half);
    clr();
    start(b);
    hdr(8'h38, a);
    for (int i = 0; i < n; i++) begin
      send(wbuf[i][7:4]);
      send(wbuf[i][3:0]);
    end
    if (half) send(wbuf[n][7:4]);
    stop();
  endtask

  task automatic mwrite(input logic [23:0] a, input int n);
    for (int i = 0; i < n; i++) begin
      int idx;
      idx = (int'(a[9:0]) + i) % MEMSZ;
      model[idx] = wbuf[i];
    end
  endtask

  task automatic qread(input logic [23:0] a, input int n);
    clr();
    start(2'd0);
    hdr(8'hEB, a);
    repeat (NDUM) send(4'h0);
    for (int i = 0; i < 2*n; i++) begin
      sclk(4'h0);
      rnib[i] = smp_io;
      if (smp_oe) data_oe++;
    end
    stop();
  endtask

  task automatic verify(input string tag, input logic [23:0] a, input int n);
    qread(a, n);
    check($sformatf("%s_hdr_oe", tag), 32'(hdr_oe), 32'd0);
    check($sformatf("%s_act", tag), 32'(hdr_act_lo), 32'd0);
    check($sformatf("%s_data_oe", tag), 32'(data_oe), 32'(2*n));
    for (int i = 0; i < n; i++) begin
      int idx;
      idx = (int'(a[9:0]) + i) % MEMSZ;
      check($sformatf("%s_b%0d", tag, i), 32'({rnib[2*i], rnib[2*i+1]}), 32'(model[idx]));
    end
    check($sformatf("%s_post_oe", tag), 32'(post_oe), 32'd0);
  endtask

  task automatic spi_init();
    logic [7:0] c;
    c = 8'h35;
    clr();
    start(2'd0);
    for (int i = 7; i >= 0; i--) send({3'b000, c[i]});
    stop();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] a;
    int n;
    reset = 1'b1; csn = 1'b1; sck = 1'b0; bnk = 2'd0; hio = 4'h0;
    repeat (4) @(negedge clock);
    check("rst_io", 32'(dio), 32'd0);
    check("rst_oe", 32'(doe), 32'd0);
    check("rst_act", 32'(dact), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

`ifdef QSPI_RESP_SPI_INIT_EN
    qread(24'h000010, 2);
    check("preinit_hdr_oe", 32'(hdr_oe), 32'd0);
    check("preinit_data_oe", 32'(data_oe), 32'd0);
    spi_init();
`endif

    wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
    qwrite(2'd0, 24'h000010, 2, 1'b0);
    mwrite(24'h000010, 2);
    check("w1_oe", 32'(hdr_oe), 32'd0);
    check("w1_act", 32'(hdr_act_lo), 32'd0);
    verify("t1", 24'h000010, 2);
    check("t1_n0", 32'(rnib[0]), 32'hA);
    check("t1_n1", 32'(rnib[1]), 32'h5);
    check("t1_n2", 32'(rnib[2]), 32'h3);
    check("t1_n3", 32'(rnib[3]), 32'hC);

    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    qwrite(2'd0, 24'h0003FF, 2, 1'b0);
    mwrite(24'h0003FF, 2);
    verify("wrap0", 24'h000000, 1);
    check("wrap0_lit", 32'({rnib[0], rnib[1]}), 32'h22);
    verify("wrap", 24'h0003FF, 2);

    wbuf[0] = 8'hFF;
    qwrite(2'd1, 24'h000000, 1, 1'b0);
    check("bank_oe", 32'(hdr_oe), 32'd0);
    check("bank_act", 32'(hdr_act_hi), 32'd0);
    verify("bank_mem", 24'h000000, 1);

    clr();
    start(2'd0);
    hdr(8'h9F, 24'h000010);
    send(4'h0); send(4'h0);
    stop();
    check("bad_cmd_oe", 32'(hdr_oe), 32'd0);
    verify("after_9f", 24'h000010, 2);

    wbuf[0] = 8'h70;
    qwrite(2'd0, 24'h000010, 0, 1'b1);
    verify("partial", 24'h000010, 1);

    clr();
    start(2'd0);
    hdr(8'hEB, 24'h000010);
    repeat (NDUM) send(4'h0);
    sclk(4'h0);
    check("mid_oe", 32'(smp_oe), 32'd1);
    check("mid_nib", 32'(smp_io), 32'hA);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_oe", 32'(doe), 32'd0);
    check("midrst_act", 32'(dact), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    sck = 1'b0;
    csn = 1'b1;
    repeat (PH) @(negedge clock);
`ifdef QSPI_RESP_SPI_INIT_EN
    spi_init();
`endif
    verify("post_rst", 24'h000010, 2);

    for (int it = 0; it < 10; it++) begin
      a = 24'($urandom);
      if (it % 3 == 0) a[9:0] = 10'h3FF - 10'($urandom_range(0, 3));
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
      qwrite(2'd0, a, n, 1'b0);
      mwrite(a, n);
      check($sformatf("rnd%0d_w_oe", it), 32'(hdr_oe), 32'd0);
      verify($sformatf("rnd%0d", it), a, n);
    end
    verify("final", 24'h0003FF, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
